// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared state encoding and frame constants for im_loader
package im_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [7:0] CSUM_INIT = 8'h00;

endpackage

// File: rtl/im_loader_word_asm.sv
// rtl/im_loader_word_asm.sv - big-endian byte-to-word assembler for im_loader
module im_loader_word_asm
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;
  logic        r_valid;
  logic [31:0] r_word;

  // Shift bytes in MSB-first; the last byte of a word completes it in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_word  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (clear) begin
        r_shift <= '0;
        r_idx   <= '0;
      end else if (byte_en) begin
        r_shift <= {r_shift[15:0], byte_data};
        r_idx   <= r_idx + 2'd1;
        if (r_idx == 2'(BYTES_PER_WORD - 1)) begin
          r_valid <= 1'b1;
          r_word  <= {r_shift, byte_data};
        end
      end
    end
  end

  assign byte_idx   = r_idx;
  assign word_valid = r_valid;
  assign word       = r_word;

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - boot-time instruction-memory loader; IM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module im_loader
  import im_loader_pkg::*;
#(
  parameter int IM_DEPTH = 256,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_loader,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] W_ONE = 1;

  state_t            r_state;
  logic              r_ready;
  logic              r_done;
  logic              r_error;
  logic              r_hold;
  logic [7:0]        r_hdr_hi;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_widx;
  logic [ADDR_W:0]   r_wcount;
  logic [ADDR_W-1:0] r_waddr;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic        w_accept;
  logic        w_restart;
  logic        w_data_byte;
  logic        w_last_byte;
  logic        w_last_word;
  logic [15:0] w_n;
  logic [1:0]  w_byte_idx;
  logic        w_word_valid;
  logic [31:0] w_word;

  assign w_accept    = byte_valid & r_ready;
  assign w_restart   = start & ((r_state == IDLE) | (r_state == DONE) | (r_state == ERR));
  assign w_data_byte = w_accept & (r_state == DATA);
  assign w_last_byte = w_data_byte & (w_byte_idx == 2'(BYTES_PER_WORD - 1));
  assign w_last_word = (r_widx == (r_n - W_ONE));
  assign w_n         = {r_hdr_hi, byte_data};

  im_loader_word_asm u_word_asm (
    .clk        (clk),
    .rst_n      (rst_loader),
    .clear      (w_restart),
    .byte_en    (w_data_byte),
    .byte_data  (byte_data),
    .byte_idx   (w_byte_idx),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  // Frame sequencing, word bookkeeping and all registered status outputs.
  always_ff @(posedge clk or negedge rst_loader) begin
    if (!rst_loader) begin
      r_state  <= IDLE;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_hold   <= 1'b1;
      r_hdr_hi <= '0;
      r_n      <= '0;
      r_widx   <= '0;
      r_wcount <= '0;
      r_waddr  <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      r_csum   <= CSUM_INIT;
`endif
    end else begin
      if (w_last_byte) begin
        r_waddr <= r_widx[ADDR_W-1:0];
        r_widx  <= r_widx + W_ONE;
      end
      // The memory commits one edge after im_we is registered.
      if (w_word_valid) r_wcount <= r_wcount + W_ONE;
`ifdef IM_LOADER_CHECKSUM_EN
      if (w_accept) r_csum <= r_csum ^ byte_data;
`endif
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state  <= HDR_HI;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_hold   <= 1'b1;
            r_widx   <= '0;
            r_wcount <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_csum   <= CSUM_INIT;
`endif
          end else if ((r_state == DONE) && !r_done) begin
            // Release the core only once the final word has been committed.
            r_done <= 1'b1;
            r_hold <= 1'b0;
          end
        end
        HDR_HI: begin
          if (w_accept) begin
            r_hdr_hi <= byte_data;
            r_state  <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (w_accept) begin
            if (w_n > 16'(IM_DEPTH)) begin
              r_state <= ERR;
              r_ready <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_n <= w_n[ADDR_W:0];
              if (w_n == 16'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
                r_state <= CSUM;
`else
                r_state <= DONE;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
`endif
              end else begin
                r_state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (w_last_byte && w_last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
            r_state <= CSUM;
`else
            r_state <= DONE;
            r_ready <= 1'b0;
`endif
          end
        end
`ifdef IM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if ((r_csum ^ byte_data) == 8'h00) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_ready;
  assign im_we      = w_word_valid;
  assign im_waddr   = r_waddr;
  assign im_wdata   = w_word;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_wcount;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed self-checking bench for im_loader
module tb_im_loader;

  logic        clk;
  logic        rst_loader;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [7:0]  im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  word_count;

  int n_checks = 0;
  int n_fail   = 0;

  int          wr_cnt = 0;
  logic [7:0]  wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];

  im_loader #(.IM_DEPTH(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst_loader (rst_loader),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe shortly after the edge that registers it.
  always @(posedge clk) begin
    #1;
    if (im_we && wr_cnt < 1024) begin
      wr_addr[wr_cnt] = im_waddr;
      wr_data[wr_cnt] = im_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 20) begin
      n_fail++;
      $display("FAIL send_timeout: byte %h, byte_ready got 0 required 1", b);
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_loader = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) @(negedge clk);
    rst_loader = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready: got %b required 0", byte_ready); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b required 1", cpu_hold); end
    n_checks++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_done_error: got %b/%b required 0/0", done, error); end
    n_checks++; if (word_count !== 9'd0 || im_waddr !== 8'd0 || im_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_regs: wc %0d addr %0d data %h required 0", word_count, im_waddr, im_wdata); end
    n_checks++; if (wr_cnt !== 0 || im_we !== 1'b0) begin n_fail++; $display("FAIL reset_no_write: writes %0d im_we %b required 0", wr_cnt, im_we); end
    byte_valid = 1'b0;
  endtask

  // Two-word frame at full rate; used after reset and after an aborted load.
  task automatic test_two_words(input string tag);
    int base;
    base = wr_cnt;
    pulse_start();
    n_checks++; if (byte_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || word_count !== 9'd0) begin
      n_fail++; $display("FAIL %s_after_start: ready %b hold %b done %b wc %0d required 1 1 0 0", tag, byte_ready, cpu_hold, done, word_count);
    end
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'hAC); send(8'h09); send(8'h00); send(8'h04);
`ifdef IM_LOADER_CHECKSUM_EN
    send(8'h8E);
    byte_valid = 1'b0;
    n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
      n_fail++; $display("FAIL %s_csum_done: done %b hold %b error %b required 1 0 0", tag, done, cpu_hold, error);
    end
`else
    byte_valid = 1'b0;
    n_checks++; if (im_we !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL %s_last_write_cycle: im_we %b done %b hold %b required 1 0 1", tag, im_we, done, cpu_hold);
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s_done: done %b hold %b ready %b required 1 0 0", tag, done, cpu_hold, byte_ready);
    end
`endif
    n_checks++; if (word_count !== 9'd2) begin n_fail++; $display("FAIL %s_word_count: got %0d required 2", tag, word_count); end
    n_checks++; if (wr_cnt - base !== 2) begin n_fail++; $display("FAIL %s_write_count: got %0d required 2", tag, wr_cnt - base); end
    n_checks++; if (wr_addr[base] !== 8'd0 || wr_data[base] !== 32'h20080005) begin
      n_fail++; $display("FAIL %s_word0: addr %0d data %h required 0 20080005", tag, wr_addr[base], wr_data[base]);
    end
    n_checks++; if (wr_addr[base+1] !== 8'd1 || wr_data[base+1] !== 32'hAC090004) begin
      n_fail++; $display("FAIL %s_word1: addr %0d data %h required 1 ac090004", tag, wr_addr[base+1], wr_data[base+1]);
    end
  endtask

  task automatic test_bad_checksum();
`ifdef IM_LOADER_CHECKSUM_EN
    pulse_start();
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'hAC); send(8'h09); send(8'h00); send(8'h04);
    send(8'hA0);
    byte_valid = 1'b0;
    n_checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || word_count !== 9'd2) begin
      n_fail++; $display("FAIL bad_csum: error %b hold %b done %b wc %0d required 1 1 0 2", error, cpu_hold, done, word_count);
    end
`endif
  endtask

  task automatic test_oversize();
    int base;
    base = wr_cnt;
    pulse_start();
    send(8'h01); send(8'h01);
    n_checks++; if (error !== 1'b1 || byte_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL oversize_err: error %b ready %b hold %b done %b required 1 0 1 0", error, byte_ready, cpu_hold, done);
    end
    byte_data = 8'hFF;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    n_checks++; if (wr_cnt - base !== 0 || word_count !== 9'd0) begin
      n_fail++; $display("FAIL oversize_no_write: writes %0d wc %0d required 0 0", wr_cnt - base, word_count);
    end
  endtask

  task automatic test_zero_words();
    int base;
    base = wr_cnt;
    pulse_start();
    send(8'h00); send(8'h00);
`ifdef IM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    byte_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || word_count !== 9'd0) begin
      n_fail++; $display("FAIL zero_words: done %b error %b hold %b wc %0d required 1 0 0 0", done, error, cpu_hold, word_count);
    end
    n_checks++; if (wr_cnt - base !== 0) begin n_fail++; $display("FAIL zero_words_writes: got %0d required 0", wr_cnt - base); end
  endtask

  task automatic test_max_image();
    int base;
    logic [7:0] b;
    base = wr_cnt;
    pulse_start();
    send(8'h01); send(8'h00);
    for (int w = 0; w < 256; w++) begin
      b = 8'(w);
      send(b); send(b); send(b); send(b);
    end
`ifdef IM_LOADER_CHECKSUM_EN
    send(8'h01);
`endif
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b1 || error !== 1'b0 || word_count !== 9'd256) begin
      n_fail++; $display("FAIL max_done: done %b error %b wc %0d required 1 0 256", done, error, word_count);
    end
    n_checks++; if (wr_cnt - base !== 256) begin n_fail++; $display("FAIL max_writes: got %0d required 256", wr_cnt - base); end
    n_checks++; if (wr_addr[base+255] !== 8'd255 || wr_data[base+255] !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL max_last_word: addr %0d data %h required 255 ffffffff", wr_addr[base+255], wr_data[base+255]);
    end
    n_checks++; if (wr_addr[base+128] !== 8'd128 || wr_data[base+128] !== 32'h80808080) begin
      n_fail++; $display("FAIL max_mid_word: addr %0d data %h required 128 80808080", wr_addr[base+128], wr_data[base+128]);
    end
  endtask

  task automatic test_async_reset();
    int base;
    base = wr_cnt;
    pulse_start();
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'hAC); send(8'h09);
    #2;
    rst_loader = 1'b0;
    #1;
    n_checks++; if (byte_ready !== 1'b0 || cpu_hold !== 1'b1 || im_we !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_outputs: ready %b hold %b im_we %b required 0 1 0", byte_ready, cpu_hold, im_we);
    end
    n_checks++; if (wr_cnt - base !== 1 || wr_addr[base] !== 8'd0) begin
      n_fail++; $display("FAIL async_reset_writes: writes %0d addr %0d required 1 0", wr_cnt - base, wr_addr[base]);
    end
    byte_valid = 1'b0;
    @(negedge clk);
    rst_loader = 1'b1;
    @(negedge clk);
    n_checks++; if (word_count !== 9'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_state: wc %0d done %b required 0 0", word_count, done);
    end
  endtask

  initial begin
    test_reset();
    test_two_words("frame");
    test_bad_checksum();
    test_oversize();
    test_zero_words();
    test_max_image();
    test_async_reset();
    test_two_words("reload");
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
